md_unit: RTL and testbench

Multi-cycle multiply/divide responder for the five-stage MIPS pipeline. The E stage issues mult/multu/div/divu/mthi/mtlo requests with forwarded rs/rt operands. The block computes the results over a fixed number of cycles and holds them in the architectural HI/LO registers, where mfhi/mflo read them. It drives `Busy` so the hazard unit can stall any dependent MD instruction in D until the result is committed.

---
 rtl/md_unit.sv | 136 +++++++++++++
 tb/tb_md_unit.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multiply/divide unit holding architectural HI/LO; the result commits MULT_CYCLES/DIV_CYCLES edges after the request.
// Busy is high for the whole run. Requests arriving while it is high are dropped, so the hazard unit must stall them.
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Start,
   input  logic [2:0]  MDOp,
   input  logic [31:0] Data1,
   input  logic [31:0] Data2,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);
   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [2:0]    op;
   logic [31:0]   opa, opb;
   logic          busy_nxt, load;
   logic [31:0]   hi_nxt, lo_nxt;

   logic [63:0] sa, sb, prod_s, prod_u;
   logic [31:0] dvd, dvs, dvs_safe, uq, ur, q_s, r_s, res_hi, res_lo;
   logic        is_sdiv, div_zero;

   assign sa     = {{32{opa[31]}}, opa};
   assign sb     = {{32{opb[31]}}, opb};
   assign prod_s = sa * sb;
   assign prod_u = {32'd0, opa} * {32'd0, opb};

   // Signed divide runs on magnitudes; the 0x80000000/-1 case falls out as 0x80000000 rem 0.
   assign is_sdiv  = (op == OP_DIV);
   assign div_zero = (opb == 32'd0);
   assign dvd      = (is_sdiv && opa[31]) ? -opa : opa;
   assign dvs      = (is_sdiv && opb[31]) ? -opb : opb;
   assign dvs_safe = div_zero ? 32'd1 : dvs;
   assign uq       = dvd / dvs_safe;
   assign ur       = dvd % dvs_safe;
   assign q_s      = (opa[31] ^ opb[31]) ? -uq : uq;
   assign r_s      = opa[31] ? -ur : ur;

   always_comb begin
      res_hi = 32'd0;
      res_lo = 32'd0;
      case (op)
         OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
         OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
         OP_DIV:   begin res_hi = r_s;           res_lo = q_s;          end
         OP_DIVU:  begin res_hi = ur;            res_lo = uq;           end
         default:  ;
      endcase
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      busy_nxt  = Busy;
      hi_nxt    = HI;
      lo_nxt    = LO;
      load      = 1'b0;
      case (state)
         IDLE: begin
            if (Start) begin
               case (MDOp)
                  OP_MULT, OP_MULTU: begin
                     load      = 1'b1;
                     cnt_nxt   = CW'(MULT_CYCLES);
                     state_nxt = RUN;
                     busy_nxt  = 1'b1;
                  end
                  OP_DIV, OP_DIVU: begin
                     load      = 1'b1;
                     cnt_nxt   = CW'(DIV_CYCLES);
                     state_nxt = RUN;
                     busy_nxt  = 1'b1;
                  end
                  OP_MTHI: hi_nxt = Data1;
                  OP_MTLO: lo_nxt = Data1;
                  default: ;
               endcase
            end
         end
         RUN: begin
            cnt_nxt = cnt - CW'(1);
            if (cnt == CW'(1)) begin
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
               // A zero divisor burns the full latency but leaves HI/LO alone.
               if (!((op == OP_DIV || op == OP_DIVU) && div_zero)) begin
                  hi_nxt = res_hi;
                  lo_nxt = res_lo;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
         cnt   <= '0;
         Busy  <= 1'b0;
         HI    <= 32'd0;
         LO    <= 32'd0;
         op    <= 3'd0;
         opa   <= 32'd0;
         opb   <= 32'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         Busy  <= busy_nxt;
         HI    <= hi_nxt;
         LO    <= lo_nxt;
         if (load) begin
            op  <= MDOp;
            opa <= Data1;
            opb <= Data2;
         end
      end
   end
endmodule

// File: tb/tb_md_unit.sv
// Directed checks of md_unit: result table, busy lengths, ignored requests, async reset mid-run.
module tb_md_unit;
   logic        Clk = 1'b0;
   logic        Reset;
   logic        Start;
   logic [2:0]  MDOp;
   logic [31:0] Data1, Data2;
   logic        Busy;
   logic [31:0] HI, LO;

   int tests = 0;
   int fails = 0;

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .MDOp(MDOp),
      .Data1(Data1), .Data2(Data2), .Busy(Busy), .HI(HI), .LO(LO)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] d1;
      logic [31:0] d2;
      int          n;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Present one request, then count how many edges Busy stays high (bounded).
   task automatic run_op(input logic [2:0] op, input logic [31:0] d1, input logic [31:0] d2,
                         output int busy_cnt);
      Start = 1'b1; MDOp = op; Data1 = d1; Data2 = d2;
      tick();
      Start = 1'b0; MDOp = 3'd0; Data1 = 32'd0; Data2 = 32'd0;
      busy_cnt = 0;
      while (Busy && busy_cnt < 50) begin
         tick();
         busy_cnt++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int bc;

      vecs[0]  = '{3'd1, 32'hFFFFFFFD, 32'd5,        5,  32'hFFFFFFFF, 32'hFFFFFFF1};
      vecs[1]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        5,  32'h00000001, 32'hFFFFFFFE};
      vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
      vecs[4]  = '{3'd5, 32'h11111111, 32'd0,        0,  32'h11111111, 32'h80000000};
      vecs[5]  = '{3'd4, 32'h12345678, 32'd0,        10, 32'h11111111, 32'h80000000};
      vecs[6]  = '{3'd4, 32'd100,      32'd7,        10, 32'h00000002, 32'h0000000E};
      vecs[7]  = '{3'd6, 32'hDEADBEEF, 32'd0,        0,  32'h00000002, 32'hDEADBEEF};
      vecs[8]  = '{3'd3, 32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
      vecs[9]  = '{3'd1, 32'h00010000, 32'h00010000, 5,  32'h00000001, 32'h00000000};
      vecs[10] = '{3'd3, 32'd5,        32'd0,        10, 32'h00000001, 32'h00000000};
      vecs[11] = '{3'd7, 32'hCAFEF00D, 32'd3,        0,  32'h00000001, 32'h00000000};
      vecs[12] = '{3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 5,  32'h3FFFFFFF, 32'h00000001};
      vecs[13] = '{3'd2, 32'h80000000, 32'd4,        5,  32'h00000002, 32'h00000000};

      Reset = 1'b1; Start = 1'b0; MDOp = 3'd0; Data1 = 32'd0; Data2 = 32'd0;
      tick();
      tick();
      chk("reset_busy", {31'd0, Busy}, 32'd0);
      chk("reset_hi", HI, 32'd0);
      chk("reset_lo", LO, 32'd0);
      Reset = 1'b0;

      for (int i = 0; i < 14; i++) begin
         run_op(vecs[i].op, vecs[i].d1, vecs[i].d2, bc);
         chk($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'(vecs[i].n));
         chk($sformatf("vec%0d_hi", i), HI, vecs[i].hi);
         chk($sformatf("vec%0d_lo", i), LO, vecs[i].lo);
      end
      // State here: HI=2, LO=0.

      // mtlo during RUN is dropped; div commits exactly at T+10.
      Start = 1'b1; MDOp = 3'd3; Data1 = 32'd100; Data2 = 32'd7;
      tick();
      Start = 1'b0; MDOp = 3'd0;
      tick();
      tick();
      Start = 1'b1; MDOp = 3'd6; Data1 = 32'h0000ABCD;
      tick();
      Start = 1'b0; MDOp = 3'd0; Data1 = 32'd0;
      chk("run_mtlo_ignored", LO, 32'd0);
      for (int k = 0; k < 6; k++) tick();
      chk("run_busy_t9", {31'd0, Busy}, 32'd1);
      chk("run_lo_t9", LO, 32'd0);
      tick();
      chk("run_busy_t10", {31'd0, Busy}, 32'd0);
      chk("run_hi_t10", HI, 32'd2);
      chk("run_lo_t10", LO, 32'd14);

      // Load distinct values, then kill a div mid-run with async reset.
      run_op(3'd5, 32'hAAAA5555, 32'd0, bc);
      Start = 1'b1; MDOp = 3'd3; Data1 = 32'd50; Data2 = 32'd3;
      tick();
      Start = 1'b0; MDOp = 3'd0;
      for (int k = 0; k < 4; k++) tick();
      chk("pre_reset_busy", {31'd0, Busy}, 32'd1);
      #1 Reset = 1'b1;
      #1;
      chk("async_reset_busy", {31'd0, Busy}, 32'd0);
      chk("async_reset_hi", HI, 32'd0);
      chk("async_reset_lo", LO, 32'd0);
      @(negedge Clk);
      Reset = 1'b0;
      for (int k = 0; k < 12; k++) tick();
      chk("post_reset_no_commit_hi", HI, 32'd0);
      chk("post_reset_no_commit_lo", LO, 32'd0);
      chk("post_reset_busy", {31'd0, Busy}, 32'd0);

      // First request after reset accepted at the first edge with Reset low.
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      Start = 1'b1; MDOp = 3'd6; Data1 = 32'h00000055;
      tick();
      Start = 1'b0; MDOp = 3'd0; Data1 = 32'd0;
      chk("first_after_reset_lo", LO, 32'h00000055);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
